// File: rtl/exec_dispatch.sv
// Execute dispatch: decodes one RV32 instruction, issues latched operands to one of NUM_FU
// variable-latency functional units and holds the result for writeback.
module exec_dispatch #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FU  = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iFLUSH,
  input  logic                   iVALID,
  output logic                   oREADY,
  input  logic [31:0]            iIR,
  output logic [4:0]             oRS1,
  output logic [4:0]             oRS2,
  input  logic [XLEN-1:0]        iRS1_DATA,
  input  logic [XLEN-1:0]        iRS2_DATA,
  output logic [NUM_FU-1:0]      oFU_VALID,
  output logic [XLEN-1:0]        oFU_IN1,
  output logic [XLEN-1:0]        oFU_IN2,
  output logic [3:0]             oFU_OP,
  input  logic [NUM_FU-1:0]      iFU_DONE,
  input  logic [NUM_FU*XLEN-1:0] iFU_RESULT,
  output logic                   oWB_VALID,
  input  logic                   iWB_READY,
  output logic [4:0]             oWB_RD,
  output logic                   oWB_WE,
  output logic [XLEN-1:0]        oWB_DATA,
  output logic                   oILLEGAL,
  output logic                   oTIMEOUT
);

  localparam int unsigned SelW = $clog2(NUM_FU);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} stateT;

  stateT             stateQ, stateD;
  logic [XLEN-1:0]   in1Q, in1D, in2Q, in2D, resultQ, resultD;
  logic [3:0]        opQ, opD;
  logic [4:0]        rdQ, rdD;
  logic [SelW-1:0]   selQ, selD;
  logic              weQ, weD, illegalQ, illegalD, timeoutQ, timeoutD;
  logic [CntW-1:0]   cntQ, cntD;

  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [3:0]        custIdx;
  logic              decLegal, useRs1, useRs2, wrRd, opHi, decWe;
  logic [SelW-1:0]   decSel;
  logic              fuDone;
  logic [XLEN-1:0]   fuRes;
  logic              issueNow;

  assign opcode  = iIR[6:0];
  assign funct3  = iIR[14:12];
  assign funct7  = iIR[31:25];
  assign custIdx = {1'b0, funct3} + 4'd3;

  always_comb begin
    decLegal = 1'b0;
    decSel   = '0;
    useRs1   = 1'b0;
    useRs2   = 1'b0;
    wrRd     = 1'b0;
    opHi     = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'h00 || funct7 == 7'h20) begin
          decLegal = 1'b1;
          useRs1   = 1'b1;
          useRs2   = 1'b1;
          wrRd     = 1'b1;
          opHi     = iIR[30];
        end else if (funct7 == 7'h01) begin
          decLegal = 1'b1;
          decSel   = SelW'(1);
          useRs1   = 1'b1;
          useRs2   = 1'b1;
          wrRd     = 1'b1;
        end
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        decLegal = 1'b1;
        useRs1   = 1'b1;
        wrRd     = 1'b1;
        opHi     = (funct3 == 3'b101) & iIR[30];
      end
      7'b0100011: begin
        decLegal = 1'b1;
        useRs1   = 1'b1;
        useRs2   = 1'b1;
      end
      7'b1100011: begin
        decLegal = 1'b1;
        decSel   = SelW'(2);
        useRs1   = 1'b1;
        useRs2   = 1'b1;
      end
      7'b0110111, 7'b0010111, 7'b1101111: begin
        decLegal = 1'b1;
        wrRd     = 1'b1;
      end
      7'b0001011: begin
        useRs2 = 1'b1;
        if (32'(custIdx) < NUM_FU) begin
          decLegal = 1'b1;
          decSel   = SelW'(custIdx);
          wrRd     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign decWe = decLegal & wrRd & (iIR[11:7] != 5'd0);
  assign oRS1  = (useRs1 && !iRST) ? iIR[19:15] : 5'd0;
  assign oRS2  = (useRs2 && !iRST) ? iIR[24:20] : 5'd0;

  // Only the selected FU's strobe and result slice are ever observed.
  always_comb begin
    fuDone = 1'b0;
    fuRes  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (selQ == SelW'(k)) begin
        fuDone = iFU_DONE[k];
        fuRes  = iFU_RESULT[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    stateD   = stateQ;
    in1D     = in1Q;
    in2D     = in2Q;
    opD      = opQ;
    rdD      = rdQ;
    selD     = selQ;
    weD      = weQ;
    resultD  = resultQ;
    illegalD = illegalQ;
    timeoutD = timeoutQ;
    cntD     = cntQ;
    if (iFLUSH) begin
      stateD   = StIdle;
      resultD  = '0;
      weD      = 1'b0;
      illegalD = 1'b0;
      timeoutD = 1'b0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (iVALID) begin
            in1D     = iRS1_DATA;
            in2D     = iRS2_DATA;
            opD      = {opHi, funct3};
            rdD      = iIR[11:7];
            selD     = decSel;
            weD      = decWe;
            resultD  = '0;
            illegalD = ~decLegal;
            timeoutD = 1'b0;
            stateD   = decLegal ? StIssue : StHold;
          end
        end
        StIssue: begin
          cntD = '0;
          if (fuDone) begin
            resultD = fuRes;
            stateD  = StHold;
          end else begin
            stateD = StWait;
          end
        end
        StWait: begin
          if (fuDone) begin
            resultD = fuRes;
            stateD  = StHold;
          end else if (cntQ == CntLast) begin
            timeoutD = 1'b1;
            weD      = 1'b0;
            resultD  = '0;
            stateD   = StHold;
          end else begin
            cntD = cntQ + 1'b1;
          end
        end
        StHold: begin
          if (iWB_READY) stateD = StIdle;
        end
        default: stateD = StIdle;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateQ   <= StIdle;
      in1Q     <= '0;
      in2Q     <= '0;
      opQ      <= '0;
      rdQ      <= '0;
      selQ     <= '0;
      weQ      <= 1'b0;
      resultQ  <= '0;
      illegalQ <= 1'b0;
      timeoutQ <= 1'b0;
      cntQ     <= '0;
    end else begin
      stateQ   <= stateD;
      in1Q     <= in1D;
      in2Q     <= in2D;
      opQ      <= opD;
      rdQ      <= rdD;
      selQ     <= selD;
      weQ      <= weD;
      resultQ  <= resultD;
      illegalQ <= illegalD;
      timeoutQ <= timeoutD;
      cntQ     <= cntD;
    end
  end

  // Outputs are forced low while reset is asserted, even before the registers clear.
  assign issueNow = (stateQ == StIssue) && !iFLUSH && !iRST;

  always_comb begin
    oFU_VALID = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      oFU_VALID[k] = issueNow && (selQ == SelW'(k));
    end
  end

  assign oREADY    = (stateQ == StIdle) && !iRST;
  assign oWB_VALID = (stateQ == StHold) && !iRST && !iFLUSH;
  assign oFU_IN1   = iRST ? '0 : in1Q;
  assign oFU_IN2   = iRST ? '0 : in2Q;
  assign oFU_OP    = iRST ? '0 : opQ;
  assign oWB_RD    = iRST ? '0 : rdQ;
  assign oWB_WE    = iRST ? 1'b0 : weQ;
  assign oWB_DATA  = iRST ? '0 : resultQ;
  assign oILLEGAL  = iRST ? 1'b0 : illegalQ;
  assign oTIMEOUT  = iRST ? 1'b0 : timeoutQ;

endmodule

// File: doc/exec_dispatch.md
Name: exec_dispatch

Overview:
- Sequential successor to the combinational operand/result router.
- Decodes one RV32 instruction into a format class and drives rs1/rs2 indices to the register file.
- Issues latched operands to one of NUM_FU variable-latency functional units (FUs) with a valid/done handshake, with timeout protection.
- Holds the result, rd and write-enable for writeback behind a valid/ready handshake.
- Sits between the register-file read stage and writeback.

Parameters:
- XLEN, 32, operand/result width.
- NUM_FU, 3, number of FU ports. Minimum 3. FU0 = ALU, FU1 = MUL/DIV, FU2 = branch compare, FU3.. = custom units.
- TIMEOUT, 64, maximum WAIT cycles before abort. Must be at least 1.

Ports:
- iCLK  in  1  clock, all state on rising edge.
- iRST  in  1  synchronous, active-high reset.
- iFLUSH  in  1  abort the current instruction.
- iVALID  in  1  instruction and operands valid.
- oREADY  out  1  block can accept an instruction.
- iIR  in  32  instruction word.
- oRS1  out  5  rs1 index, combinational from iIR.
- oRS2  out  5  rs2 index, combinational from iIR.
- iRS1_DATA  in  XLEN  rs1 value, same cycle as iVALID.
- iRS2_DATA  in  XLEN  rs2 value, same cycle as iVALID.
- oFU_VALID  out  NUM_FU  one-hot issue pulse.
- oFU_IN1  out  XLEN  latched rs1 value, shared bus.
- oFU_IN2  out  XLEN  latched rs2 value, shared bus.
- oFU_OP  out  4  {IR[30], funct3}, latched.
- iFU_DONE  in  NUM_FU  per-FU completion strobe.
- iFU_RESULT  in  NUM_FU*XLEN  FU k result in bits [k*XLEN +: XLEN].
- oWB_VALID  out  1  writeback entry valid.
- iWB_READY  in  1  writeback consumes the entry.
- oWB_RD  out  5  destination register.
- oWB_WE  out  1  register write enable.
- oWB_DATA  out  XLEN  result.
- oILLEGAL  out  1  undecodable instruction (qualified by oWB_VALID).
- oTIMEOUT  out  1  FU did not respond (qualified by oWB_VALID).

Behaviour:
- Decode classes by opcode:
  - 0110011: R if funct7 is 00 or 20. M if funct7 is 01. Otherwise illegal.
  - 0010011, 0000011, 1100111: I.
  - 0100011: S.
  - 1100011: B.
  - 0110111, 0010111: U.
  - 1101111: J.
  - 0001011: custom, FU index 3+funct3; illegal if the index is NUM_FU or above.
  - All other opcodes: illegal.
- FU routing: R/I/S/U/J go to FU0, M to FU1, B to FU2.
- oRS1 = IR[19:15] for R/M/I/S/B, else 0. oRS2 = IR[24:20] for R/M/S/B/custom, else 0.
- oFU_OP[3] = IR[30] for R, and for I when funct3 = 101. Otherwise 0.
- Write enable: oWB_WE = 1 only for R/M/I/U/J/custom with rd != 0. Always 0 for S, B, illegal and timeout.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: oREADY = 1. On iVALID & oREADY, latch IR, operands, sel and rd.
    - Legal instruction: go to ISSUE.
    - Illegal instruction: go to HOLD with oILLEGAL = 1 and oWB_DATA = 0.
  - ISSUE: oFU_VALID[sel] = 1 for exactly this cycle; clear the wait counter.
    - iFU_DONE[sel] in the same cycle: capture the result and go to HOLD.
    - Otherwise go to WAIT.
  - WAIT: counter increments each cycle.
    - iFU_DONE[sel]: capture iFU_RESULT slice sel and go to HOLD.
    - Counter reaches TIMEOUT without done: go to HOLD with oTIMEOUT = 1 and oWB_DATA = 0.
    - iFU_DONE on other bits is ignored in every state.
  - HOLD: oWB_VALID = 1 and all oWB_* / flags stable. On iWB_READY go to IDLE. No new accept until IDLE (one instruction in flight).
- Minimum latency: accept at cycle T, issue pulse T+1, oWB_VALID at T+2, next accept at T+3 when iWB_READY=1 in T+2.
- iFLUSH: in any state, next state is IDLE. Pending result, oILLEGAL and oTIMEOUT are dropped; no oFU_VALID is generated. In IDLE, iVALID together with iFLUSH is not accepted. A late FU done after flush is ignored.
- Reset: while iRST=1, the state is IDLE but oREADY = 0. All other outputs, latches and the counter are 0. oREADY = 1 from the first cycle after release. Reset mid-operation discards everything. iRST has priority over iFLUSH, and iFLUSH over all other inputs.
- Counter width: $clog2(TIMEOUT+1). It never wraps.

Test Plan:
- ADD x3,x1,x2 (IR 0x002081B3), rs1=5, rs2=7, FU0 done in ISSUE returning 12 -> oRS1=1, oRS2=2, oFU_VALID=001 pulse at T+1; oWB_VALID at T+2 with RD=3, WE=1, DATA=12.
- MUL x5,x6,x7 (0x027302B3), FU1 done 4 cycles after issue returning 42; spurious FU0 done meanwhile -> oFU_VALID=010; spurious done ignored; WB DATA=42, RD=5, WE=1.
- SW (0x0020A023) and BEQ (0x00208063), done immediately -> WE=0; BEQ routed to oFU_VALID=100.
- IR 0xFFFFFFFF -> HOLD at T+1 with ILLEGAL=1, WE=0; no oFU_VALID. Custom funct3=2 with NUM_FU=3 -> ILLEGAL.
- FU never responds, TIMEOUT=64 -> oWB_VALID exactly 64 WAIT cycles after ISSUE, with TIMEOUT=1, WE=0, DATA=0. With iWB_READY=0 held for 10 cycles, outputs stay stable.
- iFLUSH during WAIT, then a late done -> IDLE next cycle, oREADY=1, no oWB_VALID. Repeat with iRST mid-WAIT -> all outputs 0 and oREADY=0 during reset.
